// File: rtl/md_pkg.sv
// Shared types and default latencies for the HI/LO multiply/divide sequencer.
package md_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  function automatic logic is_div(input md_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Issue / mt-write / status bundle between the E stage, hazard unit and md_ctrl.
interface md_ctrl_if;
  import md_pkg::*;

  logic        issue_valid;
  md_op_t      issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic        mt_valid;
  logic        mt_sel;
  logic [31:0] mt_data;
  logic        exc_int;
  logic        d_md_use;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  issue_valid, issue_op, issue_a, issue_b,
    input  mt_valid, mt_sel, mt_data, exc_int, d_md_use,
    output start, busy, stall_md, done, hi, lo
  );

  modport master (
    output issue_valid, issue_op, issue_a, issue_b,
    output mt_valid, mt_sel, mt_data, exc_int, d_md_use,
    input  start, busy, stall_md, done, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational 32x32 product and quotient/remainder for the HI/LO unit.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic        [31:0] abs_a;
  logic        [31:0] abs_b;
  logic        [31:0] sq_u;
  logic        [31:0] sr_u;
  logic        [31:0] uq;
  logic        [31:0] ur;

  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'd0, a_i} * {32'd0, b_i};
    // Divisor forced non-zero so the dividers never yield X; the result is discarded anyway.
    b_safe = (b_i == 32'd0) ? 32'd1 : b_i;
    abs_a  = a_i[31] ? (~a_i + 32'd1) : a_i;
    abs_b  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    sq_u   = abs_a / abs_b;
    sr_u   = abs_a % abs_b;
    uq     = a_i / b_safe;
    ur     = a_i % b_safe;
    wr_o   = !(is_div(op_i) && (b_i == 32'd0));
    hi_o   = prod_s[63:32];
    lo_o   = prod_s[31:0];
    case (op_i)
      MULT: begin
        hi_o = prod_s[63:32];
        lo_o = prod_s[31:0];
      end
      MULTU: begin
        hi_o = prod_u[63:32];
        lo_o = prod_u[31:0];
      end
      // Magnitude divide then re-sign; 0x80000000 / -1 naturally wraps to 0x80000000 rem 0.
      DIV: begin
        lo_o = (a_i[31] ^ b_safe[31]) ? (~sq_u + 32'd1) : sq_u;
        hi_o = a_i[31] ? (~sr_u + 32'd1) : sr_u;
      end
      DIVU: begin
        lo_o = uq;
        hi_o = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency counter, pending result, commit and stall.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_ctrl_if.slave   bus
);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic               p_wr_q, p_wr_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               start;
  logic [31:0]        ar_hi, ar_lo;
  logic               ar_wr;

  md_arith u_arith (
    .op_i (bus.issue_op),
    .a_i  (bus.issue_a),
    .b_i  (bus.issue_b),
    .hi_o (ar_hi),
    .lo_o (ar_lo),
    .wr_o (ar_wr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_wr_d  = p_wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.issue_valid && !bus.exc_int) begin
          start   = 1'b1;
          p_hi_d  = ar_hi;
          p_lo_d  = ar_lo;
          p_wr_d  = ar_wr;
          cnt_d   = is_div(bus.issue_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          state_d = RUN;
        end else if (bus.mt_valid && !bus.exc_int && !bus.issue_valid) begin
          if (bus.mt_sel) hi_d = bus.mt_data;
          else            lo_d = bus.mt_data;
        end
      end
      RUN: begin
        // New issues and mt writes are ignored here; the D-stage stall keeps them away.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == RUN) && (cnt_d == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_wr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_wr_q  <= p_wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.start    = start;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.stall_md = bus.d_md_use & (start | busy_q);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl.
module tb_md_ctrl;
  import md_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  md_ctrl_if md_bus ();

  md_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (md_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && md_bus.busy && (md_bus.issue_valid || md_bus.mt_valid)) begin
      errors++;
      $display("FAIL issue_during_run: issue_valid=%0b mt_valid=%0b while busy", md_bus.issue_valid, md_bus.mt_valid);
    end
  end

  task automatic idle_inputs;
    md_bus.issue_valid = 1'b0;
    md_bus.issue_op    = MULT;
    md_bus.issue_a     = 32'd0;
    md_bus.issue_b     = 32'd0;
    md_bus.mt_valid    = 1'b0;
    md_bus.mt_sel      = 1'b0;
    md_bus.mt_data     = 32'd0;
    md_bus.exc_int     = 1'b0;
    md_bus.d_md_use    = 1'b0;
  endtask

  // Issues one op and follows it until busy drops; returns observed start, busy count, done count and position.
  task automatic do_issue(input bit wait_edge, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic start_seen, output int busy_n, output int done_n, output int done_at);
    if (wait_edge) @(negedge clk);
    md_bus.issue_valid = 1'b1;
    md_bus.issue_op    = op;
    md_bus.issue_a     = a;
    md_bus.issue_b     = b;
    #1 start_seen = md_bus.start;
    @(negedge clk);
    md_bus.issue_valid = 1'b0;
    md_bus.mt_valid    = 1'b0;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!md_bus.busy) break;
      busy_n++;
      if (md_bus.done) begin
        done_n++;
        done_at = busy_n;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({md_bus.busy, md_bus.done, md_bus.start, md_bus.stall_md} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/start/stall=%b required 0000", {md_bus.busy, md_bus.done, md_bus.start, md_bus.stall_md});
    end
    checks++;
    if ({md_bus.hi, md_bus.lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", md_bus.hi, md_bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("reset released: hi=%h lo=%h", md_bus.hi, md_bus.lo);
  endtask

  task automatic test_mult_stall;
    @(negedge clk);
    md_bus.d_md_use    = 1'b1;
    md_bus.issue_valid = 1'b1;
    md_bus.issue_op    = MULT;
    md_bus.issue_a     = 32'd3;
    md_bus.issue_b     = 32'hFFFF_FFFE;
    #1;
    checks++;
    if ({md_bus.start, md_bus.stall_md, md_bus.busy} !== 3'b110) begin
      errors++;
      $display("FAIL mult_issue: start/stall/busy=%b required 110", {md_bus.start, md_bus.stall_md, md_bus.busy});
    end
    @(negedge clk);
    md_bus.issue_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++;
      if ({md_bus.busy, md_bus.done, md_bus.stall_md} !== {1'b1, (k == 5), 1'b1}) begin
        errors++;
        $display("FAIL mult_run T+%0d: busy/done/stall=%b required %b", k,
                 {md_bus.busy, md_bus.done, md_bus.stall_md}, {1'b1, (k == 5), 1'b1});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({md_bus.busy, md_bus.done, md_bus.stall_md} !== 3'b000) begin
      errors++;
      $display("FAIL mult_end: busy/done/stall=%b required 000", {md_bus.busy, md_bus.done, md_bus.stall_md});
    end
    checks++;
    if (md_bus.hi !== 32'hFFFF_FFFF || md_bus.lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h required ffffffff/fffffffa", md_bus.hi, md_bus.lo);
    end
    md_bus.d_md_use = 1'b0;
    $display("mult 3 x fffffffe: hi=%h lo=%h", md_bus.hi, md_bus.lo);
  endtask

  task automatic test_arith;
    md_op_t      ops [5] = '{MULTU, DIVU, DIV, DIV, MULT};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] elo [5] = '{32'h0000_0001, 32'd3, 32'hFFFF_FFFD, 32'h8000_0000, 32'd42};
    int          elat[5] = '{5, 10, 10, 10, 5};
    logic st;
    int bn, dn, da;
    for (int i = 0; i < 5; i++) begin
      do_issue(1'b1, ops[i], as[i], bs[i], st, bn, dn, da);
      checks++;
      if (st !== 1'b1 || bn != elat[i] || dn != 1 || da != elat[i]) begin
        errors++;
        $display("FAIL arith%0d_timing: start=%b busy=%0d done=%0d@%0d required 1/%0d/1@%0d", i, st, bn, dn, da, elat[i], elat[i]);
      end
      checks++;
      if (md_bus.hi !== ehi[i] || md_bus.lo !== elo[i]) begin
        errors++;
        $display("FAIL arith%0d_result: hi=%h lo=%h required %h/%h", i, md_bus.hi, md_bus.lo, ehi[i], elo[i]);
      end
      $display("op=%0d a=%h b=%h: hi=%h lo=%h busy=%0d", ops[i], as[i], bs[i], md_bus.hi, md_bus.lo, bn);
    end
  endtask

  // HI/LO hold 0 / 42 on entry.
  task automatic test_exc_kill;
    @(negedge clk);
    md_bus.issue_valid = 1'b1;
    md_bus.issue_op    = MULTU;
    md_bus.issue_a     = 32'd5;
    md_bus.issue_b     = 32'd5;
    md_bus.exc_int     = 1'b1;
    md_bus.d_md_use    = 1'b1;
    #1;
    checks++;
    if ({md_bus.start, md_bus.stall_md} !== 2'b00) begin
      errors++;
      $display("FAIL exc_issue: start/stall=%b required 00", {md_bus.start, md_bus.stall_md});
    end
    @(negedge clk);
    md_bus.issue_valid = 1'b0;
    md_bus.d_md_use    = 1'b0;
    md_bus.mt_valid    = 1'b1;
    md_bus.mt_sel      = 1'b0;
    md_bus.mt_data     = 32'h1234;
    #1;
    checks++;
    if (md_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL exc_busy: busy=%b required 0", md_bus.busy);
    end
    @(negedge clk);
    md_bus.mt_valid = 1'b0;
    md_bus.exc_int  = 1'b0;
    #1;
    checks++;
    if (md_bus.hi !== 32'd0 || md_bus.lo !== 32'd42 || md_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL exc_hilo: hi=%h lo=%h busy=%b required 0/2a/0", md_bus.hi, md_bus.lo, md_bus.busy);
    end
    $display("killed issue and mtlo: hi=%h lo=%h", md_bus.hi, md_bus.lo);
  endtask

  task automatic test_div_zero;
    logic st;
    int bn, dn, da;
    @(negedge clk);
    md_bus.mt_valid = 1'b1;
    md_bus.mt_sel   = 1'b1;
    md_bus.mt_data  = 32'hAAAA;
    @(negedge clk);
    md_bus.mt_sel   = 1'b0;
    md_bus.mt_data  = 32'h5555;
    @(negedge clk);
    md_bus.mt_valid = 1'b0;
    #1;
    checks++;
    if (md_bus.hi !== 32'hAAAA || md_bus.lo !== 32'h5555) begin
      errors++;
      $display("FAIL mt_write: hi=%h lo=%h required aaaa/5555", md_bus.hi, md_bus.lo);
    end
    do_issue(1'b1, DIV, 32'd5, 32'd0, st, bn, dn, da);
    checks++;
    if (st !== 1'b1 || bn != 10 || dn != 1 || da != 10) begin
      errors++;
      $display("FAIL divzero_timing: start=%b busy=%0d done=%0d@%0d required 1/10/1@10", st, bn, dn, da);
    end
    checks++;
    if (md_bus.hi !== 32'hAAAA || md_bus.lo !== 32'h5555) begin
      errors++;
      $display("FAIL divzero_hilo: hi=%h lo=%h required aaaa/5555", md_bus.hi, md_bus.lo);
    end
    $display("div 5/0: hi=%h lo=%h busy=%0d", md_bus.hi, md_bus.lo, bn);
  endtask

  task automatic test_back_to_back;
    logic st;
    int bn, dn, da;
    // Issue and mthi in the same cycle: the issue wins and the mt write is dropped.
    @(negedge clk);
    md_bus.mt_valid = 1'b1;
    md_bus.mt_sel   = 1'b1;
    md_bus.mt_data  = 32'h77;
    do_issue(1'b0, MULTU, 32'd2, 32'd2, st, bn, dn, da);
    checks++;
    if (st !== 1'b1 || bn != 5 || md_bus.hi !== 32'd0 || md_bus.lo !== 32'd4) begin
      errors++;
      $display("FAIL issue_vs_mt: start=%b busy=%0d hi=%h lo=%h required 1/5/0/4", st, bn, md_bus.hi, md_bus.lo);
    end
    do_issue(1'b1, MULT, 32'hFFFF_FFFF, 32'd7, st, bn, dn, da);
    do_issue(1'b0, DIVU, 32'd100, 32'd7, st, bn, dn, da);
    checks++;
    if (st !== 1'b1 || bn != 10 || dn != 1) begin
      errors++;
      $display("FAIL b2b_timing: start=%b busy=%0d done=%0d required 1/10/1", st, bn, dn);
    end
    checks++;
    if (md_bus.hi !== 32'd2 || md_bus.lo !== 32'd14) begin
      errors++;
      $display("FAIL b2b_result: hi=%h lo=%h required 2/e", md_bus.hi, md_bus.lo);
    end
    $display("back-to-back divu 100/7: hi=%h lo=%h", md_bus.hi, md_bus.lo);
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    md_bus.issue_valid = 1'b1;
    md_bus.issue_op    = DIV;
    md_bus.issue_a     = 32'd50;
    md_bus.issue_b     = 32'd3;
    @(negedge clk);
    md_bus.issue_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (md_bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: busy=%b required 1", md_bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (md_bus.busy !== 1'b0 || md_bus.done !== 1'b0 || md_bus.hi !== 32'd0 || md_bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b hi=%h lo=%h required 0/0/0/0", md_bus.busy, md_bus.done, md_bus.hi, md_bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    md_bus.mt_valid = 1'b1;
    md_bus.mt_sel   = 1'b1;
    md_bus.mt_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    md_bus.mt_valid = 1'b0;
    #1;
    checks++;
    if (md_bus.hi !== 32'hDEAD_BEEF || md_bus.lo !== 32'd0 || md_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mthi: hi=%h lo=%h busy=%b required deadbeef/0/0", md_bus.hi, md_bus.lo, md_bus.busy);
    end
    $display("reset mid-div then mthi: hi=%h lo=%h", md_bus.hi, md_bus.lo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult_stall();
    test_arith();
    test_exc_kill();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Sequencing controller for the HI/LO multiply/divide resource of the five-stage pipeline. Accepts mult/multu/div/divu issues from the E stage and mthi/mtlo writes. Models each operation's fixed latency with a counter and commits the result to HI/LO at completion. Generates the `start`/`busy` pair and the D-stage stall request consumed by the hazard unit. An issue in the same cycle as `exc_int` is killed, so an instruction squashed by an exception never touches HI/LO.

## Interface
Parameters:
- `MULT_LAT`, 5: busy cycles for mult/multu.
- `DIV_LAT`, 10: busy cycles for div/divu.
- `CNT_W`, 4: latency counter width; must hold `DIV_LAT`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: E-stage instruction is mult/multu/div/divu.
- `issue_op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `issue_a` in 32: forwarded rs value.
- `issue_b` in 32: forwarded rt value.
- `mt_valid` in 1: E-stage mthi/mtlo.
- `mt_sel` in 1: 1 = HI, 0 = LO.
- `mt_data` in 32: forwarded rs value.
- `exc_int` in 1: exception/interrupt taken this cycle; kills any E-stage issue or mt write.
- `d_md_use` in 1: D-stage instruction is any MD op or mfhi/mflo/mthi/mtlo.
- `start` out 1: combinational; accepted issue this cycle.
- `busy` out 1: registered; operation in flight.
- `stall_md` out 1: combinational; `d_md_use & (start | busy)`.
- `done` out 1: registered one-cycle pulse in the commit cycle.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `issue_valid & ~exc_int` -> `start`=1.
  - Compute the result from `issue_a`/`issue_b` into the pending registers `p_hi`/`p_lo`.
  - Load `cnt` with MULT_LAT or DIV_LAT and go to RUN.
- IDLE, `mt_valid & ~exc_int`: write `mt_data` to the selected register at the next edge.
- Simultaneous issue and mt in IDLE: issue wins; the mt write is dropped (illegal per decode, but behaviour is fixed).
- RUN:
  - `busy`=1 and `cnt` decrements each cycle.
  - At `cnt`==1: commit `p_hi`/`p_lo` to `hi`/`lo`, pulse `done`, return to IDLE.
- RUN, new issue or mt: ignored. Under a correct stall these cannot occur; the bench checks this with an assertion.
- `exc_int` during RUN: no effect. The in-flight instruction is older than the faulting one and completes.
- Arithmetic:
  - mult: signed 32x32 -> 64; `hi` = [63:32], `lo` = [31:0].
  - multu: unsigned 32x32 -> 64, same split.
  - div: `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Division by zero: the operation still runs DIV_LAT cycles, but `hi`/`lo` stay unchanged.
- div 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.

## Timing
- Issue accepted in cycle T: `start` high in T; `busy` high T+1..T+LAT; `done` high in T+LAT; new `hi`/`lo` visible from T+LAT+1.
- `busy` falls in T+LAT+1, so a back-to-back issue can be accepted in T+LAT+1.
- `stall_md` holds a D-stage mfhi/mflo/MD op from T through T+LAT. The op leaves D in T+LAT+1 and reads committed values; no HI/LO forwarding from this block is needed.
- mt write in cycle T: `hi`/`lo` updated at the T edge, visible T+1.
- Reset (asynchronous, any time, including mid-RUN):
  - State IDLE; `cnt`=0; `busy`=0; `done`=0.
  - `hi`=`lo`=0; `p_hi`=`p_lo`=0.
  - The in-flight result is discarded.
  - `start`/`stall_md` are combinational, so they are 0 unless inputs assert them.

## Structure
- Shared package `md_pkg` holds:
  - `md_op_t` (MULT, MULTU, DIV, DIVU);
  - `md_state_t` (IDLE, RUN);
  - default latency constants.
- One natural sub-module `md_arith`: combinational 64-bit product and quotient/remainder with the divide-by-zero and overflow rules above. `md_ctrl` holds the FSM, counter and registers.

## Test plan
- mult 3 x 0xFFFFFFFE at T -> `busy` T+1..T+5, `done` at T+5; at T+6 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- divu 7 / 2 -> after 10 busy cycles `lo`=3, `hi`=1. Also check div 0xFFFFFFF9 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Issue with `exc_int`=1 in the same cycle -> `start`=0, `busy` stays 0, `hi`/`lo` unchanged. Repeat with mtlo 0x1234 + `exc_int` -> `lo` unchanged.
- `d_md_use`=1 held from issue cycle T through commit of a mult -> `stall_md`=1 for exactly T..T+5, then 0.
- div by 0 with `hi`=0xAAAA, `lo`=0x5555 -> `busy` for 10 cycles, `done` pulses, `hi`/`lo` unchanged.
- Reset asserted at cycle 3 of a div -> `busy`=0 immediately and `hi`=`lo`=0. After release, mthi 0xDEADBEEF -> `hi`=0xDEADBEEF next cycle.
